// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode map, default legal-opcode mask and pipeline control encoding
package hazard_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LD  = 4'd10;
  localparam logic [3:0] OP_ST  = 4'd11;
  localparam logic [3:0] OP_BEQ = 4'd12;
  localparam logic [3:0] OP_BNE = 4'd13;
  localparam logic [3:0] OP_JAL = 4'd15;
  localparam logic [15:0] VALID_OP_MASK_DEF = 16'hBCF7;
  typedef struct packed {
    logic pc_ctrl;
    logic buffer_ctrl;
    logic ctrl_mux;
  } ctrl_t;
  localparam ctrl_t CTRL_RUN   = 3'b110;
  localparam ctrl_t CTRL_STALL = 3'b001;
  localparam ctrl_t CTRL_FLUSH = 3'b111;
endpackage

// File: rtl/hazard_if.sv
// hazard_if: IF/ID and ID/EX view of the hazard unit with its control and debug outputs
interface hazard_if #(
  parameter int REG_AW = 4,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
);
  logic              ifIdValid;
  logic [OP_W-1:0]   opCode;
  logic [REG_AW-1:0] ifIdOp1;
  logic [REG_AW-1:0] ifIdOp2;
  logic              idExValid;
  logic              idExMemRead;
  logic [REG_AW-1:0] idExRd;
  logic              flush;
  logic              errClear;
  logic              statClear;
  logic              pcCtrl;
  logic              bufferCtrl;
  logic              ctrlMux;
  logic              opCodeError;
  logic              errSticky;
  logic [OP_W-1:0]   errOpCode;
  logic [CNT_W-1:0]  stallCount;
  modport master (
    output ifIdValid, opCode, ifIdOp1, ifIdOp2, idExValid, idExMemRead, idExRd,
           flush, errClear, statClear,
    input  pcCtrl, bufferCtrl, ctrlMux, opCodeError, errSticky, errOpCode, stallCount
  );
  modport slave (
    input  ifIdValid, opCode, ifIdOp1, ifIdOp2, idExValid, idExMemRead, idExRd,
           flush, errClear, statClear,
    output pcCtrl, bufferCtrl, ctrlMux, opCodeError, errSticky, errOpCode, stallCount
  );
endinterface

// File: rtl/hazard_scoreboard_load_shadow.sv
// load_shadow: free-running valid/rd delay line for loads past ID/EX, entry 0 is the youngest
module load_shadow #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 0,
  localparam int N = DEPTH > 0 ? DEPTH : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [REG_AW-1:0]   in_rd,
  output logic [N-1:0]        valid,
  output logic [N*REG_AW-1:0] rd
);
  if (DEPTH > 0) begin : g_sh
    logic [N-1:0]        valid_q, valid_d;
    logic [N*REG_AW-1:0] rd_q, rd_d;
    always_comb begin
      valid_d = (valid_q << 1) | N'(in_valid);
      rd_d    = (rd_q << REG_AW) | (N*REG_AW)'(in_rd);
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        valid_q <= '0;
        rd_q    <= '0;
      end else begin
        valid_q <= valid_d;
        rd_q    <= rd_d;
      end
    assign valid = valid_q;
    assign rd    = rd_q;
  end else begin : g_none
    // Single-cycle latency needs no history; the tie-off keeps the ports consumed.
    logic unused;
    assign unused = ^{clk, rst, in_valid, in_rd};
    assign valid  = '0;
    assign rd     = '0;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use stall/bubble control with illegal-opcode capture and stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int                   REG_AW        = 4,
  parameter int                   OP_W          = 4,
  parameter int                   LOAD_LAT      = 1,
  parameter logic [2**OP_W-1:0]   VALID_OP_MASK = VALID_OP_MASK_DEF,
  parameter bit                   ZERO_REG      = 1'b1,
  parameter int                   CNT_W         = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);
  localparam int SD = LOAD_LAT > 1 ? LOAD_LAT - 1 : 0;
  localparam int N  = SD > 0 ? SD : 1;
  logic                ld_v, ex_hit, hazard, op_err;
  logic [N-1:0]        sh_v, sh_hit;
  logic [N*REG_AW-1:0] sh_rd;
  ctrl_t               ctrl;
  logic                err_sticky_q, err_sticky_d;
  logic [OP_W-1:0]     err_op_q, err_op_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  assign ld_v = bus.idExValid & bus.idExMemRead & !(ZERO_REG && bus.idExRd == '0);
  load_shadow #(.REG_AW(REG_AW), .DEPTH(SD)) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ld_v),
    .in_rd    (bus.idExRd),
    .valid    (sh_v),
    .rd       (sh_rd)
  );
  for (genvar k = 0; k < N; k++) begin : g_cmp
    assign sh_hit[k] = sh_v[k] & (sh_rd[k*REG_AW +: REG_AW] == bus.ifIdOp1 ||
                                  sh_rd[k*REG_AW +: REG_AW] == bus.ifIdOp2);
  end
  assign ex_hit = ld_v & (bus.idExRd == bus.ifIdOp1 || bus.idExRd == bus.ifIdOp2);
  assign hazard = bus.ifIdValid & !bus.flush & (ex_hit | (|sh_hit));
  assign op_err = bus.ifIdValid & !VALID_OP_MASK[bus.opCode];
  // A squashed slot still needs a bubble, so flush forces the mux but keeps the PC moving.
  assign ctrl = bus.flush ? CTRL_FLUSH : hazard ? CTRL_STALL : CTRL_RUN;
  always_comb begin
    err_sticky_d = (op_err && !err_sticky_q) ? 1'b1 : bus.errClear ? 1'b0 : err_sticky_q;
    err_op_d     = (op_err && !err_sticky_q) ? bus.opCode : bus.errClear ? '0 : err_op_q;
    stall_cnt_d  = bus.statClear ? '0 :
                   (hazard && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_op_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_op_q     <= err_op_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  assign bus.pcCtrl      = ctrl.pc_ctrl;
  assign bus.bufferCtrl  = ctrl.buffer_ctrl;
  assign bus.ctrlMux     = ctrl.ctrl_mux;
  assign bus.opCodeError = op_err;
  assign bus.errSticky   = err_sticky_q;
  assign bus.errOpCode   = err_op_q;
  assign bus.stallCount  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: four configurations driven in lockstep and checked against a load-history model
module tb_hazard_scoreboard;
  localparam int NI = 4;
  int lat_c [NI] = '{1, 3, 2, 1};
  int zr_c  [NI] = '{1, 1, 1, 0};
  int cw_c  [NI] = '{16, 16, 16, 2};
  logic clk = 1'b0;
  logic rst;
  logic ifv, exv, exm, fl, ec, scl;
  logic [3:0] opc, op1, op2, exrd;
  logic pc [NI], bf [NI], mx [NI], oe [NI], es [NI];
  logic [3:0] eo [NI];
  logic [15:0] sc [NI];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  hazard_if #(.CNT_W(16)) bA ();
  hazard_if #(.CNT_W(16)) bB ();
  hazard_if #(.CNT_W(16)) bC ();
  hazard_if #(.CNT_W(2))  bD ();
  assign {bA.ifIdValid, bA.opCode, bA.ifIdOp1, bA.ifIdOp2, bA.idExValid, bA.idExMemRead, bA.idExRd, bA.flush, bA.errClear, bA.statClear} = {ifv, opc, op1, op2, exv, exm, exrd, fl, ec, scl};
  assign {bB.ifIdValid, bB.opCode, bB.ifIdOp1, bB.ifIdOp2, bB.idExValid, bB.idExMemRead, bB.idExRd, bB.flush, bB.errClear, bB.statClear} = {ifv, opc, op1, op2, exv, exm, exrd, fl, ec, scl};
  assign {bC.ifIdValid, bC.opCode, bC.ifIdOp1, bC.ifIdOp2, bC.idExValid, bC.idExMemRead, bC.idExRd, bC.flush, bC.errClear, bC.statClear} = {ifv, opc, op1, op2, exv, exm, exrd, fl, ec, scl};
  assign {bD.ifIdValid, bD.opCode, bD.ifIdOp1, bD.ifIdOp2, bD.idExValid, bD.idExMemRead, bD.idExRd, bD.flush, bD.errClear, bD.statClear} = {ifv, opc, op1, op2, exv, exm, exrd, fl, ec, scl};
  assign {pc[0], bf[0], mx[0], oe[0], es[0], eo[0], sc[0]} = {bA.pcCtrl, bA.bufferCtrl, bA.ctrlMux, bA.opCodeError, bA.errSticky, bA.errOpCode, bA.stallCount};
  assign {pc[1], bf[1], mx[1], oe[1], es[1], eo[1], sc[1]} = {bB.pcCtrl, bB.bufferCtrl, bB.ctrlMux, bB.opCodeError, bB.errSticky, bB.errOpCode, bB.stallCount};
  assign {pc[2], bf[2], mx[2], oe[2], es[2], eo[2], sc[2]} = {bC.pcCtrl, bC.bufferCtrl, bC.ctrlMux, bC.opCodeError, bC.errSticky, bC.errOpCode, bC.stallCount};
  assign {pc[3], bf[3], mx[3], oe[3], es[3], eo[3], sc[3]} = {bD.pcCtrl, bD.bufferCtrl, bD.ctrlMux, bD.opCodeError, bD.errSticky, bD.errOpCode, 14'd0, bD.stallCount};
  hazard_scoreboard                                      uA (.clk(clk), .rst(rst), .bus(bA));
  hazard_scoreboard #(.LOAD_LAT(3))                      uB (.clk(clk), .rst(rst), .bus(bB));
  hazard_scoreboard #(.LOAD_LAT(2))                      uC (.clk(clk), .rst(rst), .bus(bC));
  hazard_scoreboard #(.ZERO_REG(1'b0), .CNT_W(2))        uD (.clk(clk), .rst(rst), .bus(bD));

  // Reference: a load issued from ID/EX 'a' cycles ago blocks its rd while a < LOAD_LAT.
  logic hl [1:2];
  logic [3:0] hr [1:2];
  int mcnt [NI];
  logic mes;
  logic [3:0] meo;
  function automatic bit legal(input logic [3:0] o);
    return o inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
  endfunction
  function automatic bit mhz(input int i);
    bit m = 0;
    for (int a = 0; a < lat_c[i]; a++) begin
      bit l;
      logic [3:0] r;
      l = (a == 0) ? (exv & exm) : hl[a];
      r = (a == 0) ? exrd : hr[a];
      if (l && !(zr_c[i] != 0 && r == 4'd0) && (r == op1 || r == op2)) m = 1;
    end
    return ifv && !fl && m;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      hl[1] <= 0; hl[2] <= 0; hr[1] <= 0; hr[2] <= 0;
      for (int i = 0; i < NI; i++) mcnt[i] <= 0;
      mes <= 0;
      meo <= 0;
    end else begin
      for (int i = 0; i < NI; i++)
        mcnt[i] <= scl ? 0 : (mhz(i) && mcnt[i] < (1 << cw_c[i]) - 1) ? mcnt[i] + 1 : mcnt[i];
      if (ifv && !legal(opc) && !mes) begin
        mes <= 1; meo <= opc;
      end else if (ec) begin
        mes <= 0; meo <= 0;
      end
      hl[2] <= hl[1]; hr[2] <= hr[1];
      hl[1] <= exv & exm; hr[1] <= exrd;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    ifv = 0; opc = 0; op1 = 0; op2 = 0; exv = 0; exm = 0; exrd = 0; fl = 0; ec = 0; scl = 0;
  endtask
  task automatic quiesce;
    idle();
    repeat (3) tick();
    scl = 1;
    tick();
    scl = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    idle();
    #12;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({pc[i], bf[i], mx[i], es[i]} !== 4'b1100 || sc[i] !== 16'd0 || eo[i] !== 4'd0) begin
        n_bad++;
        $display("FAIL reset[%0d]: pc/buf/mux/err=%b sc=%0d eo=%0d, want 1100 sc=0 eo=0", i, {pc[i], bf[i], mx[i], es[i]}, sc[i], eo[i]);
      end
    end
    @(negedge clk) rst = 0;
    tick();
  endtask

  task automatic test_lat1;
    quiesce();
    ifv = 1; op1 = 3; op2 = 9; exv = 1; exm = 1; exrd = 3;
    #1;
    n_cmp++;
    if ({pc[0], bf[0], mx[0]} !== 3'b001) begin
      n_bad++; $display("FAIL lat1_stall: ctrl=%b, want 001", {pc[0], bf[0], mx[0]});
    end
    tick();
    exv = 0;
    #1;
    n_cmp++;
    if ({pc[0], bf[0], mx[0]} !== 3'b110 || sc[0] !== 16'd1) begin
      n_bad++; $display("FAIL lat1_release: ctrl=%b sc=%0d, want 110 sc=1", {pc[0], bf[0], mx[0]}, sc[0]);
    end
  endtask

  task automatic test_latency;
    int st [NI];
    int exp1 [NI] = '{1, 3, 2, 1};
    int exp2 [NI] = '{0, 2, 1, 0};
    quiesce();
    st = '{0, 0, 0, 0};
    ifv = 1; op1 = 1; op2 = 5; exv = 1; exm = 1; exrd = 5;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int i = 0; i < NI; i++) if (!pc[i]) st[i]++;
      tick();
      exv = 0;
    end
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (st[i] !== exp1[i]) begin
        n_bad++; $display("FAIL stall_dist1[%0d]: stalls=%0d, want %0d", i, st[i], exp1[i]);
      end
    end
    n_cmp++;
    if (sc[1] !== 16'd3) begin
      n_bad++; $display("FAIL stall_count_lat3: sc=%0d, want 3", sc[1]);
    end
    quiesce();
    st = '{0, 0, 0, 0};
    ifv = 1; op1 = 2; op2 = 2; exv = 1; exm = 1; exrd = 5;
    #1;
    for (int i = 0; i < NI; i++) if (!pc[i]) st[i]++;
    tick();
    op1 = 1; op2 = 5; exv = 1; exm = 0; exrd = 2;
    for (int c = 0; c < 5; c++) begin
      #1;
      for (int i = 0; i < NI; i++) if (!pc[i]) st[i]++;
      tick();
      exv = 0;
    end
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (st[i] !== exp2[i]) begin
        n_bad++; $display("FAIL stall_dist2[%0d]: stalls=%0d, want %0d", i, st[i], exp2[i]);
      end
    end
  endtask

  task automatic test_zero_reg;
    quiesce();
    ifv = 1; op1 = 0; op2 = 7; exv = 1; exm = 1; exrd = 0;
    #1;
    n_cmp++;
    if (pc[0] !== 1'b1 || mx[0] !== 1'b0) begin
      n_bad++; $display("FAIL zero_reg_on: pc=%b mux=%b, want 1 0", pc[0], mx[0]);
    end
    n_cmp++;
    if (pc[3] !== 1'b0 || mx[3] !== 1'b1) begin
      n_bad++; $display("FAIL zero_reg_off: pc=%b mux=%b, want 0 1", pc[3], mx[3]);
    end
    tick();
    idle();
  endtask

  task automatic test_flush;
    quiesce();
    ifv = 1; op1 = 3; exv = 1; exm = 1; exrd = 3; fl = 1;
    #1;
    n_cmp++;
    if ({pc[0], bf[0], mx[0]} !== 3'b111 || {pc[3], bf[3], mx[3]} !== 3'b111) begin
      n_bad++; $display("FAIL flush_ctrl: A=%b D=%b, want 111", {pc[0], bf[0], mx[0]}, {pc[3], bf[3], mx[3]});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (sc[0] !== 16'd0) begin
      n_bad++; $display("FAIL flush_count: sc=%0d, want 0", sc[0]);
    end
  endtask

  task automatic test_errors;
    idle();
    ec = 1;
    tick();
    ec = 0; opc = 3;
    #1;
    n_cmp++;
    if (oe[0] !== 1'b0) begin
      n_bad++; $display("FAIL err_invalid_slot: opCodeError=%b, want 0", oe[0]);
    end
    ifv = 1;
    #1;
    n_cmp++;
    if (oe[0] !== 1'b1) begin
      n_bad++; $display("FAIL err_comb_3: opCodeError=%b, want 1", oe[0]);
    end
    tick();
    n_cmp++;
    if (es[0] !== 1'b1 || eo[0] !== 4'd3) begin
      n_bad++; $display("FAIL err_first: sticky=%b op=%0d, want 1 3", es[0], eo[0]);
    end
    opc = 8;
    #1;
    n_cmp++;
    if (oe[0] !== 1'b1) begin
      n_bad++; $display("FAIL err_comb_8: opCodeError=%b, want 1", oe[0]);
    end
    tick();
    n_cmp++;
    if (es[0] !== 1'b1 || eo[0] !== 4'd3) begin
      n_bad++; $display("FAIL err_hold: sticky=%b op=%0d, want 1 3", es[0], eo[0]);
    end
    opc = 0; ec = 1;
    tick();
    n_cmp++;
    if (es[0] !== 1'b0 || eo[0] !== 4'd0) begin
      n_bad++; $display("FAIL err_clear: sticky=%b op=%0d, want 0 0", es[0], eo[0]);
    end
    opc = 8;
    tick();
    n_cmp++;
    if (es[0] !== 1'b1 || eo[0] !== 4'd8) begin
      n_bad++; $display("FAIL err_vs_clear: sticky=%b op=%0d, want 1 8", es[0], eo[0]);
    end
    idle();
    ec = 1;
    tick();
    ec = 0;
  endtask

  task automatic test_saturate;
    quiesce();
    ifv = 1; op1 = 3; exv = 1; exm = 1; exrd = 3;
    repeat (5) tick();
    n_cmp++;
    if (sc[3] !== 16'd3 || sc[0] !== 16'd5) begin
      n_bad++; $display("FAIL saturate: D sc=%0d A sc=%0d, want 3 5", sc[3], sc[0]);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall;
    quiesce();
    ifv = 1; op1 = 5; opc = 3; exv = 1; exm = 1; exrd = 5;
    tick();
    exv = 0;
    #1;
    n_cmp++;
    if (pc[2] !== 1'b0 || es[2] !== 1'b1 || sc[2] !== 16'd1) begin
      n_bad++; $display("FAIL pre_reset: pc=%b err=%b sc=%0d, want 0 1 1", pc[2], es[2], sc[2]);
    end
    @(negedge clk) rst = 1;
    #1;
    n_cmp++;
    if (pc[2] !== 1'b1 || sc[2] !== 16'd0 || es[2] !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_stall: pc=%b sc=%0d err=%b, want 1 0 0", pc[2], sc[2], es[2]);
    end
    exv = 1;
    #1;
    n_cmp++;
    if (pc[2] !== 1'b0 || mx[2] !== 1'b1) begin
      n_bad++; $display("FAIL reset_idex_hazard: pc=%b mux=%b, want 0 1", pc[2], mx[2]);
    end
    @(negedge clk) rst = 0;
    idle();
    tick();
  endtask

  task automatic test_random;
    logic [2:0] ex;
    idle();
    for (int c = 0; c < 400; c++) begin
      ifv  = $urandom_range(0, 3) != 0;
      opc  = 4'($urandom_range(0, 15));
      op1  = 4'($urandom_range(0, 3));
      op2  = 4'($urandom_range(0, 3));
      exv  = 1'($urandom_range(0, 1));
      exm  = $urandom_range(0, 2) != 0;
      exrd = 4'($urandom_range(0, 3));
      fl   = $urandom_range(0, 7) == 0;
      ec   = $urandom_range(0, 9) == 0;
      scl  = $urandom_range(0, 19) == 0;
      #1;
      for (int i = 0; i < NI; i++) begin
        ex = fl ? 3'b111 : mhz(i) ? 3'b001 : 3'b110;
        n_cmp++;
        if ({pc[i], bf[i], mx[i]} !== ex || sc[i] !== 16'(mcnt[i])) begin
          n_bad++; $display("FAIL rand_ctrl[%0d] cyc %0d: ctrl=%b sc=%0d, want %b sc=%0d", i, c, {pc[i], bf[i], mx[i]}, sc[i], ex, mcnt[i]);
        end
        n_cmp++;
        if (oe[i] !== (ifv && !legal(opc)) || es[i] !== mes || eo[i] !== meo) begin
          n_bad++; $display("FAIL rand_err[%0d] cyc %0d: oe=%b sticky=%b op=%0d, want %b %b %0d", i, c, oe[i], es[i], eo[i], ifv && !legal(opc), mes, meo);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_lat1();
    test_latency();
    test_zero_reg();
    test_flush();
    test_errors();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised load-use hazard unit for the in-order pipeline's IF/ID stage.
- Tracks in-flight loads over a configurable load latency and stalls the PC and IF/ID buffer while a dependent instruction waits, inserting bubbles through the control mux.
- Checks opcodes against a parametrised legal-opcode mask, keeps a sticky first-error capture, and provides a saturating stall-cycle counter for performance debug.

Parameters:
- REG_AW, 4, register specifier width.
- OP_W, 4, opcode width.
- LOAD_LAT, 1, cycles a load result is unavailable after leaving ID/EX (legal range is 1 or more). Shadow depth is LOAD_LAT-1.
- VALID_OP_MASK, 16'hBCF7, one bit per opcode, 1 = legal. Width is 2**OP_W. The default makes opcodes 0,1,2,4,5,6,7,10,11,12,13,15 legal.
- ZERO_REG, 1, if 1 then register 0 never creates a hazard.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ifIdValid  in  1  IF/ID holds a real instruction
- opCode  in  OP_W  IF/ID opcode
- ifIdOp1  in  REG_AW  IF/ID source 1
- ifIdOp2  in  REG_AW  IF/ID source 2
- idExValid  in  1  ID/EX holds a real instruction
- idExMemRead  in  1  ID/EX instruction is a load
- idExRd  in  REG_AW  ID/EX destination
- flush  in  1  IF/ID is being squashed this cycle (branch taken)
- errClear  in  1  clears sticky error capture
- statClear  in  1  clears stall counter
- pcCtrl  out  1  1 = PC advances
- bufferCtrl  out  1  1 = IF/ID loads
- ctrlMux  out  1  1 = zero control into ID/EX (bubble)
- opCodeError  out  1  combinational: current IF/ID opcode illegal
- errSticky  out  1  registered: an illegal opcode has been seen
- errOpCode  out  OP_W  first offending opcode
- stallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow register: an array of LOAD_LAT-1 entries, each holding a valid bit and an rd.
  - Entry 0 loads every cycle with {idExValid & idExMemRead & !(ZERO_REG & idExRd==0), idExRd}.
  - Entry k loads from entry k-1.
  - Shifts unconditionally; stages after ID/EX never stall.
  - With LOAD_LAT=1 there is no shadow and the unit is the classic single-cycle load-use check.
- Per-entry match: valid, and rd equals ifIdOp1 or ifIdOp2. The current ID/EX load is treated as one more entry.
- hazard = ifIdValid & !flush & (ID/EX load match, or any shadow match).
- Outputs are combinational:
  - hazard=1: pcCtrl=0, bufferCtrl=0, ctrlMux=1.
  - flush=1: pcCtrl=1, bufferCtrl=1, ctrlMux=1. Flush overrides hazard.
  - Otherwise: pcCtrl=1, bufferCtrl=1, ctrlMux=0.
- A dependent instruction directly behind a load stalls exactly LOAD_LAT cycles. At distance d it stalls max(0, LOAD_LAT-d+1) cycles.
- opCodeError = ifIdValid & !VALID_OP_MASK[opCode]. It is independent of hazard.
- Sticky capture, evaluated on clk rising edge:
  - If opCodeError & !errSticky: errSticky<=1 and errOpCode<=opCode.
  - Else if errClear: errSticky<=0, errOpCode<=0.
  - If errClear and a new error occur in the same cycle, the error wins. errOpCode holds the first error until cleared.
- stallCount increments on every cycle with hazard=1 and saturates at all-ones. statClear clears it; statClear takes priority over increment.
- Reset (asynchronous, active-high): shadow valids, errSticky, errOpCode and stallCount go to 0. Combinational outputs then reflect the inputs with an empty shadow.
- Reset mid-stall: shadow-held hazards vanish immediately. An ID/EX-driven hazard persists while its inputs persist.

Decomposition:
- Shared package hazard_pkg: opcode localparams, default VALID_OP_MASK, and a ctrl struct typedef {pcCtrl, bufferCtrl, ctrlMux}.
- Sub-module load_shadow: the parametrised valid/rd shift register. It exposes a flat per-entry valid/rd bus and is generated empty when LOAD_LAT=1.
- Compare logic and counters stay in the top module.

Test Plan:
1. LOAD_LAT=1: idExMemRead=1, idExRd=3, ifIdOp1=3 -> pcCtrl=0, bufferCtrl=0, ctrlMux=1 for 1 cycle. Next cycle with idExValid=0 -> pcCtrl=1, bufferCtrl=1, ctrlMux=0. stallCount=1.
2. LOAD_LAT=3: load rd=5 with dependent ifIdOp2=5 directly behind -> exactly 3 stall cycles. With the dependent at distance 2 -> 2 stall cycles.
3. ZERO_REG=1: load rd=0 with ifIdOp1=0 -> no stall. With ZERO_REG=0 -> 1 stall.
4. Hazard and flush in the same cycle -> pcCtrl=1, bufferCtrl=1, ctrlMux=1, and stallCount is not incremented.
5. Opcode sequence 4'b0011, then 4'b1000, then errClear -> opCodeError=1 on each. errOpCode=3 with errSticky=1 after the first, unchanged after the second, and 0 after errClear. Asserting errClear together with opcode 8 -> errSticky=1, errOpCode=8.
6. CNT_W=2 with 5 consecutive stall cycles -> stallCount saturates at 3. Assert rst mid-stall with LOAD_LAT=2 -> shadow cleared, stallCount=0, errSticky=0.
